// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I opcodes, immediate formats and the decoded-beat layout.
package rv32i_pkg;
  localparam logic [6:0] OP = 7'b0110011, OP_IMM = 7'b0010011, LOAD = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011, BRANCH = 7'b1100011, JALR = 7'b1100111;
  localparam logic [6:0] JAL = 7'b1101111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    imm_type_e  imm_type;
    logic       illegal;
  } dec_fields_t;
  // A stored beat is {pc, imm, fields}; pc and imm are XLEN wide.
  function automatic int beat_w(input int xlen);
    return 2 * xlen + $bits(dec_fields_t);
  endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: RV32I immediate reassembly and sign extension to XLEN.
module imm_gen import rv32i_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type
);
  logic [6:0]  op;
  logic [31:0] raw;
  assign op = inst[6:0];
  always_comb begin
    imm_type = (op == OP_IMM || op == LOAD || op == JALR) ? IMM_I :
               (op == STORE) ? IMM_S :
               (op == BRANCH) ? IMM_B :
               (op == LUI || op == AUIPC) ? IMM_U :
               (op == JAL) ? IMM_J : IMM_NONE;
    raw = (imm_type == IMM_I) ? {{20{inst[31]}}, inst[31:20]} :
          (imm_type == IMM_S) ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
          (imm_type == IMM_B) ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
          (imm_type == IMM_U) ? {inst[31:12], 12'b0} :
          (imm_type == IMM_J) ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
          32'd0;
    imm = XLEN'($signed(raw));
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode behind a two-entry skid buffer.
// Define DECODE_ILLEGAL_CHECK_EN to build the out_illegal encoding check.
module decode_stage import rv32i_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic [16:0]     out_cu_info,
  output logic            out_illegal
);
  localparam int BW = beat_w(XLEN);
  // State bits double as {out_valid, in_ready} so both come straight from flops.
  typedef enum logic [1:0] {EMPTY = 2'b01, FULL = 2'b11, SKID = 2'b10} state_e;
  state_e          state, state_nx;
  dec_fields_t     f, mf;
  imm_type_e       imm_type;
  logic [XLEN-1:0] imm;
  logic [BW-1:0]   main_q, skid_q;
  logic [6:0]      op;
  logic [2:0]      f3;
  logic            known, has_f3, illegal;
  logic            in_fire, out_fire, ld_main, ld_skid, from_skid;
  imm_gen #(.XLEN(XLEN)) u_imm_gen (.inst(in_inst), .imm(imm), .imm_type(imm_type));
  assign op = in_inst[6:0];
  assign f3 = in_inst[14:12];
  assign known = (imm_type != IMM_NONE) || (op == OP);
  assign has_f3 = known && op != LUI && op != AUIPC && op != JAL;
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic [6:0] f7;
  assign f7 = in_inst[31:25];
  assign illegal = !known
    || (op == OP && !(f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
    || (op == OP_IMM && f3[1:0] == 2'b01 && !(f7 == 7'd0 || (f7 == 7'b0100000 && f3 == 3'b101)))
    || (op == JALR && f3 != 3'd0)
    || (op == LOAD && (f3 == 3'd3 || f3 >= 3'd6))
    || (op == STORE && f3 > 3'd2)
    || (op == BRANCH && f3[2:1] == 2'b01);
`else
  assign illegal = 1'b0;
`endif
  always_comb begin
    f = '0;
    f.opcode = known ? op : 7'd0;
    f.funct3 = has_f3 ? f3 : 3'd0;
    f.funct7 = (op == OP) ? in_inst[31:25] :
               (op == OP_IMM && f3[1:0] == 2'b01) ? (in_inst[31:25] & 7'b0100000) : 7'd0;
    f.rd = (known && op != STORE && op != BRANCH) ? in_inst[11:7] : 5'd0;
    f.rs1 = has_f3 ? in_inst[19:15] : 5'd0;
    f.rs2 = (op == OP || op == STORE || op == BRANCH) ? in_inst[24:20] : 5'd0;
    f.imm_type = imm_type;
    f.illegal = illegal;
  end
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_comb begin
    ld_main = !flush && in_fire && (state == EMPTY || out_fire);
    ld_skid = !flush && in_fire && state == FULL && !out_fire;
    from_skid = !flush && state == SKID && out_fire;
    state_nx = flush ? EMPTY :
               ld_skid ? SKID :
               (ld_main || from_skid) ? FULL :
               (state == FULL && out_fire) ? EMPTY : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nx;
      if (ld_main) main_q <= {in_pc, imm, f};
      else if (from_skid) main_q <= skid_q;
      if (ld_skid) skid_q <= {in_pc, imm, f};
    end
  end
  assign in_ready = state[0];
  assign out_valid = state[1];
  assign {out_pc, out_imm, mf} = main_q;
  assign out_opcode = mf.opcode;
  assign out_funct3 = mf.funct3;
  assign out_rd = mf.rd;
  assign out_rs1 = mf.rs1;
  assign out_rs2 = mf.rs2;
  assign out_imm_type = mf.imm_type;
  assign out_cu_info = {mf.funct7, mf.funct3, mf.opcode};
  assign out_illegal = mf.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode, backpressure, flush and reset.
module tb_decode_stage;
  logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_inst = 0, in_pc = 0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3, out_imm_type;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [16:0] out_cu_info;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_pc64, out_imm64;
  logic [6:0]  out_opcode64;
  logic [2:0]  out_funct3_64, out_imm_type64;
  logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;
  logic [16:0] out_cu_info64;
  int errors = 0, checks = 0;
`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_funct3(out_funct3), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_imm_type(out_imm_type),
    .out_cu_info(out_cu_info), .out_illegal(out_illegal));

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc({32'd0, in_pc}), .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(out_pc64), .out_opcode(out_opcode64), .out_funct3(out_funct3_64), .out_rd(out_rd64),
    .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_imm(out_imm64), .out_imm_type(out_imm_type64),
    .out_cu_info(out_cu_info64), .out_illegal(out_illegal64));

  always #5 clk = ~clk;

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst = inst;
    in_pc = pc;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (out_imm !== 32'd0 || out_cu_info !== 17'd0 || out_pc !== 32'd0) begin
      errors++; $display("FAIL reset_data got imm=%h cu=%h pc=%h want 0", out_imm, out_cu_info, out_pc); end
  endtask

  task automatic test_decode;
    out_ready = 1'b1;
    offer(32'hFFF00093, 32'h0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_latency got out_valid=%0b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b want 1", out_valid); end
    checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0 || out_rs2 !== 5'd0) begin
      errors++; $display("FAIL addi_regs got rd=%0d rs1=%0d rs2=%0d want 1 0 0", out_rd, out_rs1, out_rs2); end
    checks++; if (out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %h want ffffffff", out_imm); end
    checks++; if (out_cu_info !== {7'h00, 3'b000, 7'b0010011}) begin errors++; $display("FAIL addi_cu got %h want 00013", out_cu_info); end
    checks++; if (out_imm_type !== 3'd1 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL addi_type got type=%0d ill=%0b want 1 0", out_imm_type, out_illegal); end
    checks++; if (out_imm64 !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL addi_imm64 got %h want all ones", out_imm64); end
    offer(32'hFE000EE3, 32'h4);
    @(negedge clk);
    checks++; if (out_imm !== 32'hFFFFFFFC || out_imm_type !== 3'd3 || out_rd !== 5'd0) begin
      errors++; $display("FAIL beq got imm=%h type=%0d rd=%0d want fffffffc 3 0", out_imm, out_imm_type, out_rd); end
    checks++; if (out_pc !== 32'h4 || out_cu_info !== {7'h00, 3'b000, 7'b1100011}) begin
      errors++; $display("FAIL beq_pc_cu got pc=%h cu=%h want 4 00063", out_pc, out_cu_info); end
    offer(32'h001000EF, 32'h8);
    @(negedge clk);
    checks++; if (out_imm !== 32'h00000800 || out_rd !== 5'd1 || out_funct3 !== 3'd0 || out_imm_type !== 3'd5) begin
      errors++; $display("FAIL jal got imm=%h rd=%0d f3=%0d type=%0d want 800 1 0 5", out_imm, out_rd, out_funct3, out_imm_type); end
    offer(32'hFE20AC23, 32'hC);
    @(negedge clk);
    checks++; if (out_imm !== 32'hFFFFFFF8 || out_imm_type !== 3'd2 || out_funct3 !== 3'd2) begin
      errors++; $display("FAIL sw_imm got imm=%h type=%0d f3=%0d want fffffff8 2 2", out_imm, out_imm_type, out_funct3); end
    checks++; if (out_rd !== 5'd0 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin
      errors++; $display("FAIL sw_regs got rd=%0d rs1=%0d rs2=%0d want 0 1 2", out_rd, out_rs1, out_rs2); end
    offer(32'h800002B7, 32'h10);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_imm !== 32'h80000000 || out_rd !== 5'd5 || out_imm_type !== 3'd4 || out_rs1 !== 5'd0) begin
      errors++; $display("FAIL lui got imm=%h rd=%0d type=%0d rs1=%0d want 80000000 5 4 0", out_imm, out_rd, out_imm_type, out_rs1); end
    checks++; if (out_imm64 !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL lui_imm64 got %h want ffffffff80000000", out_imm64); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL decode_drain got out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    offer(32'h00100093, 32'h100);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_a got %0b want 1", in_ready); end
    offer(32'h00200113, 32'h104);
    @(negedge clk);
    offer(32'h00300193, 32'h108);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_skid got in_ready=%0b out_valid=%0b want 0 1", in_ready, out_valid); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_rd !== 5'd1 || out_pc !== 32'h100) begin
      errors++; $display("FAIL bp_hold_a got in_ready=%0b rd=%0d pc=%h want 0 1 100", in_ready, out_rd, out_pc); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd2 || out_imm !== 32'd2 || out_pc !== 32'h104) begin
      errors++; $display("FAIL bp_b got v=%0b rd=%0d imm=%h pc=%h want 1 2 2 104", out_valid, out_rd, out_imm, out_pc); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_drain got %0b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_imm !== 32'd3 || out_pc !== 32'h108) begin
      errors++; $display("FAIL bp_c got v=%0b rd=%0d imm=%h pc=%h want 1 3 3 108", out_valid, out_rd, out_imm, out_pc); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    offer(32'h00400213, 32'h200);
    @(negedge clk);
    offer(32'h00500293, 32'h204);
    @(negedge clk);
    flush = 1'b1;
    offer(32'h00600313, 32'h208);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state got out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready); end
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got out_valid=%0b want 0", out_valid); end
    offer(32'h00700393, 32'h20C);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_pc !== 32'h20C) begin
      errors++; $display("FAIL flush_recover got v=%0b rd=%0d pc=%h want 1 7 20c", out_valid, out_rd, out_pc); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    offer(32'h00800413, 32'h300);
    @(negedge clk);
    offer(32'h00900493, 32'h304);
    @(negedge clk);
    rst_n = 1'b0;
    flush = 1'b1;
    offer(32'h00A00513, 32'h308);
    @(negedge clk);
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_state got out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready); end
    checks++; if (out_imm !== 32'd0 || out_pc !== 32'd0 || out_rd !== 5'd0 || out_cu_info !== 17'd0 || out_imm_type !== 3'd0) begin
      errors++; $display("FAIL rst_mid_data got imm=%h pc=%h rd=%0d cu=%h type=%0d want 0", out_imm, out_pc, out_rd, out_cu_info, out_imm_type); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_skid_cleared got out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    offer(32'h00000000, 32'h400);
    @(negedge clk);
    offer(32'h02000033, 32'h404);
    checks++; if (out_valid !== 1'b1 || out_illegal !== ILL || out_opcode !== 7'd0 || out_imm_type !== 3'd0) begin
      errors++; $display("FAIL ill_zero got v=%0b ill=%0b op=%h type=%0d want 1 %0b 0 0", out_valid, out_illegal, out_opcode, out_imm_type, ILL); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_illegal !== ILL || out_pc !== 32'h404) begin
      errors++; $display("FAIL ill_mul got v=%0b ill=%0b pc=%h want 1 %0b 404", out_valid, out_illegal, out_pc, ILL); end
    checks++; if (out_cu_info !== {7'b0000001, 3'b000, 7'b0110011}) begin
      errors++; $display("FAIL ill_mul_cu got %h want 00233", out_cu_info); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL ill_drain got out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_decode;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_illegal;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked successor to the combinational RV32I decoder. It sits between fetch and execute and accepts one instruction and PC per beat. It produces fully reassembled, sign-extended immediates, register indices and the 17-bit control-unit word. A two-entry skid buffer keeps `in_ready` free of any combinational path from `out_ready`.

## Interface
- `XLEN`, default 32: datapath width. Legal values are 32 and 64. Immediates and PC are XLEN wide.
- `clk` input 1: clock.
- `rst_n` input 1: reset. Synchronous, active-low, one clock (`clk`).
- `flush` input 1: synchronous pipeline kill.
- `in_valid` input 1: fetch beat valid.
- `in_ready` output 1: stage can accept a beat. Driven directly from a register.
- `in_inst` input 32: instruction word.
- `in_pc` input XLEN: instruction PC.
- `out_valid` output 1: decoded beat valid.
- `out_ready` input 1: execute accepts the beat.
- `out_pc` output XLEN: PC passed through.
- `out_opcode` output 7, `out_funct3` output 3: instruction fields.
- `out_rd` output 5, `out_rs1` output 5, `out_rs2` output 5: register indices. Zero when the format does not use them.
- `out_imm` output XLEN: sign-extended immediate. Zero for R-type.
- `out_imm_type` output 3: immediate format, encoded as NONE/I/S/B/U/J.
- `out_cu_info` output 17: `{funct7_eff, funct3, opcode}`.
- `out_illegal` output 1: unsupported encoding.

## Operation
- Decode is combinational on `in_inst`. The result is captured into the main register or the skid register.
- Immediates:
  - I: sext `inst[31:20]`.
  - S: sext `{inst[31:25], inst[11:7]}`.
  - B: sext `{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}`.
  - U: `{inst[31:12], 12'b0}`, sign-extended to XLEN.
  - J: sext `{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}`.
- `funct7_eff`:
  - OP (0110011): `inst[31:25]`.
  - OP-IMM (0010011) with funct3 001 or 101: `inst[31:25] & 7'b0100000`. Otherwise 0.
  - All other opcodes: 0.
- funct3 is zero for LUI, AUIPC and JAL.
- Unknown opcode: every field is 0 and `out_imm_type` = NONE.
- Handshake:
  - in_fire = `in_valid & in_ready`.
  - out_fire = `out_valid & out_ready`.
  - Output fields stay stable while `out_valid & ~out_ready`.
- States:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - FULL: `out_valid`=1, `in_ready`=1.
  - SKID: `out_valid`=1, `in_ready`=0.
- Transitions:
  - EMPTY + in_fire → FULL. The main register loads.
  - FULL + in_fire + out_fire → FULL. The main register reloads.
  - FULL + in_fire only → SKID. The skid register loads.
  - FULL + out_fire only → EMPTY.
  - SKID + out_fire → FULL. The main register takes the skid contents.
  - Otherwise the state holds.
- Order is strictly FIFO. No beat is dropped or duplicated.
- `flush`=1 forces EMPTY. Any beat presented in the same cycle is discarded, even if `in_ready` was 1.

## Timing
- Latency: an accepted beat appears on the outputs one cycle later.
- Throughput: one beat per cycle when `out_ready` is held high.
- `in_ready` is registered. It falls the cycle after the skid register loads and rises the cycle after the skid drains.
- Reset (`rst_n`=0 at a rising edge):
  - State goes to EMPTY, `out_valid`=0, `in_ready`=1.
  - Every data output and the skid contents go to 0.
  - Reset takes priority over `flush` and over any handshake, including mid-skid.

## Configuration
- `DECODE_ILLEGAL_CHECK_EN` defined: `out_illegal`=1 when any of the following holds:
  - the opcode is outside the nine RV32I opcodes;
  - OP funct7 is not 0000000, or not 0100000 with funct3 000/101;
  - OP-IMM shift funct7 is not 0000000, or not 0100000 with funct3 101;
  - JALR funct3 ≠ 000;
  - load funct3 is 011, 110 or 111;
  - store funct3 > 010;
  - branch funct3 is 010 or 011.
  - Illegal beats still flow through the handshake normally.
- Macro undefined: `out_illegal` is tied to 0 and no checking logic is built.

## Structure
- Shared package `rv32i_pkg` holds:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC);
  - the `imm_type_e` enum;
  - the decoded-beat struct, whose width is parameterised by XLEN.
- Sub-module `imm_gen`: combinational `inst` → (`imm`, `imm_type`), parameterised by XLEN.

## Test plan
- `0xFFF00093` (addi x1,x0,-1) → `out_rd`=1, `out_rs1`=0, `out_imm`=0xFFFFFFFF, `out_cu_info`=`{7'h00, 3'b000, 7'b0010011}`. Output appears one cycle after acceptance.
- `0xFE000EE3` (beq x0,x0,-4) → `out_imm`=0xFFFFFFFC, type B, `out_rd`=0.
- `0x001000EF` (jal x1,+2048) → `out_imm`=0x00000800, `out_rd`=1, funct3=0. With XLEN=64, `0xFFF00093` gives `out_imm`=0xFFFFFFFFFFFFFFFF.
- Backpressure:
  - Hold `out_ready`=0 and offer three beats A, B, C. A and B are accepted, and `in_ready` reads 0 from the cycle after B is accepted.
  - Raise `out_ready`. The outputs deliver A, B, C in order on consecutive cycles, with no loss.
- Flush and reset mid-operation:
  - In SKID, assert `flush` together with `in_valid`. Next cycle `out_valid`=0, `in_ready`=1, and the flushed beats never appear.
  - Repeat with `rst_n`=0. All outputs are 0.
- `0x00000000` and `0x02000033` (mul) → `out_illegal`=1 with `DECODE_ILLEGAL_CHECK_EN`, 0 without. Both beats still complete the handshake.
